// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the SRAM port-0 arbiter.
// Imported by sram_arb_rr and sram_port_arbiter.
package sram_arb_pkg;

    // Requester identifier: 0 = requester 0, 1 = requester 1.
    typedef logic [0:0] req_id_t;

    // One slot of the response pipeline.
    typedef struct packed {
        logic    valid;
        req_id_t id;
        logic    we;
    } pipe_entry_t;

    // Cycles from grant to response.
    localparam int unsigned RSP_LATENCY = 2;

    // After reset, requester 1 counts as last granted, so requester 0
    // wins the first tie.
    localparam req_id_t RST_LAST_GRANT = 1'b1;

    // Map a one-hot grant to the id of the winning requester.
    function automatic req_id_t grant_to_id(input logic [1:0] grant);
        return grant[1];
    endfunction

endpackage

// File: rtl/sram_arb_rr.sv
// Two-way arbiter: round-robin by default, fixed priority (requester 0
// always wins ties) when SRAM_PORT_ARBITER_FIXED_PRIO_EN is defined.
module sram_arb_rr
    import sram_arb_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] valid_i,
    input  logic       advance_i,
    output logic [1:0] grant_o
);

`ifdef SRAM_PORT_ARBITER_FIXED_PRIO_EN

    // No pointer state: clock, reset and advance are intentionally idle.
    logic unused_fixed_prio;
    assign unused_fixed_prio = ^{clk_i, rst_ni, advance_i};

    // Requester 0 first, requester 1 only when 0 is idle.
    always_comb begin
        grant_o = 2'b00;
        if (valid_i[0]) begin
            grant_o = 2'b01;
        end else if (valid_i[1]) begin
            grant_o = 2'b10;
        end
    end

`else

    req_id_t last_q;
    req_id_t last_d;

    // Pick the sole requester, or on a tie the one not granted last.
    always_comb begin
        grant_o = valid_i;
        if (valid_i == 2'b11) begin
            grant_o = (last_q == 1'b1) ? 2'b01 : 2'b10;
        end
        last_d = last_q;
        if (advance_i && (grant_o != 2'b00)) begin
            last_d = grant_to_id(grant_o);
        end
    end

    // Last-granted pointer, moves only when a grant is taken.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_q <= RST_LAST_GRANT;
        end else begin
            last_q <= last_d;
        end
    end

`endif

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares SRAM macro port 0 between two valid/ready requesters and
// returns in-order responses. Option: SRAM_PORT_ARBITER_FIXED_PRIO_EN.
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_WMASKS = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,

    input  logic                  req0_valid_i,
    output logic                  req0_ready_o,
    input  logic                  req0_we_i,
    input  logic [ADDR_WIDTH-1:0] req0_addr_i,
    input  logic [DATA_WIDTH-1:0] req0_wdata_i,
    input  logic [NUM_WMASKS-1:0] req0_wmask_i,
    output logic                  rsp0_valid_o,
    output logic [DATA_WIDTH-1:0] rsp0_rdata_o,

    input  logic                  req1_valid_i,
    output logic                  req1_ready_o,
    input  logic                  req1_we_i,
    input  logic [ADDR_WIDTH-1:0] req1_addr_i,
    input  logic [DATA_WIDTH-1:0] req1_wdata_i,
    input  logic [NUM_WMASKS-1:0] req1_wmask_i,
    output logic                  rsp1_valid_o,
    output logic [DATA_WIDTH-1:0] rsp1_rdata_o,

    output logic                  sram_csb0_o,
    output logic                  sram_web0_o,
    output logic [NUM_WMASKS-1:0] sram_wmask0_o,
    output logic [ADDR_WIDTH-1:0] sram_addr0_o,
    output logic [DATA_WIDTH-1:0] sram_din0_o,
    input  logic [DATA_WIDTH-1:0] sram_dout0_i
);

    // Stage whose entry captures macro read data, and stage driving rsp.
    localparam int unsigned CAP_STAGE = RSP_LATENCY - 2;
    localparam int unsigned OUT_STAGE = RSP_LATENCY - 1;

    logic [1:0]            vld;
    logic [1:0]            grant;
    logic                  xfer;
    req_id_t               sel_id;
    logic                  sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic [NUM_WMASKS-1:0] sel_wmask;

    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] din_q, din_d;
    logic [NUM_WMASKS-1:0] wmask_q, wmask_d;

    pipe_entry_t           pipe_q [RSP_LATENCY];
    pipe_entry_t           pipe_d [RSP_LATENCY];
    pipe_entry_t           cap;
    logic [DATA_WIDTH-1:0] cap_data;
    logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d;
    logic [DATA_WIDTH-1:0] rdata1_q, rdata1_d;

    // Reset masks requests so csb0 deasserts as soon as rst_ni falls.
    assign vld = {req1_valid_i, req0_valid_i} & {2{rst_ni}};

    sram_arb_rr u_rr (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .valid_i   (vld),
        .advance_i (xfer),
        .grant_o   (grant)
    );

    assign xfer         = |grant;
    assign sel_id       = grant_to_id(grant);
    assign req0_ready_o = grant[0];
    assign req1_ready_o = grant[1];

    // Steer the winning request's fields onto the macro bus.
    always_comb begin
        sel_we    = req0_we_i;
        sel_addr  = req0_addr_i;
        sel_wdata = req0_wdata_i;
        sel_wmask = req0_wmask_i;
        if (grant[1]) begin
            sel_we    = req1_we_i;
            sel_addr  = req1_addr_i;
            sel_wdata = req1_wdata_i;
            sel_wmask = req1_wmask_i;
        end
    end

    // Bus fields follow the grant, otherwise hold so idle cycles stay quiet.
    always_comb begin
        addr_d  = addr_q;
        din_d   = din_q;
        wmask_d = wmask_q;
        if (xfer) begin
            addr_d  = sel_addr;
            din_d   = sel_wdata;
            wmask_d = sel_wmask;
        end
    end

    assign sram_csb0_o   = ~xfer;
    assign sram_web0_o   = xfer ? ~sel_we : 1'b1;
    assign sram_addr0_o  = addr_d;
    assign sram_din0_o   = din_d;
    assign sram_wmask0_o = wmask_d;

    // Remember the last driven bus fields for idle cycles.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            addr_q  <= '0;
            din_q   <= '0;
            wmask_q <= '0;
        end else begin
            addr_q  <= addr_d;
            din_q   <= din_d;
            wmask_q <= wmask_d;
        end
    end

    // Shift the issued access down the response pipeline.
    always_comb begin
        pipe_d[0].valid = xfer;
        pipe_d[0].id    = sel_id;
        pipe_d[0].we    = sel_we;
        for (int i = 1; i < RSP_LATENCY; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    // Pipeline slots; reset drops anything in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < RSP_LATENCY; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < RSP_LATENCY; i++) begin
                pipe_q[i] <= pipe_d[i];
            end
        end
    end

    // Capture macro data for reads (zero for writes) into the issuer's slot.
    always_comb begin
        cap      = pipe_q[CAP_STAGE];
        cap_data = cap.we ? '0 : sram_dout0_i;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        if (cap.valid) begin
            if (cap.id == 1'b1) begin
                rdata1_d = cap_data;
            end else begin
                rdata0_d = cap_data;
            end
        end
    end

    // Per-requester read data registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    assign rsp0_rdata_o = rdata0_q;
    assign rsp1_rdata_o = rdata1_q;
    assign rsp0_valid_o = pipe_q[OUT_STAGE].valid &&
                          (pipe_q[OUT_STAGE].id == 1'b0);
    assign rsp1_valid_o = pipe_q[OUT_STAGE].valid &&
                          (pipe_q[OUT_STAGE].id == 1'b1);

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed testbench for sram_port_arbiter with a behavioural SRAM model.
// Expectations switch with SRAM_PORT_ARBITER_FIXED_PRIO_EN.
module tb_sram_port_arbiter;

    logic        clk;
    logic        rst_ni;
    logic        req0_valid_i, req0_ready_o, req0_we_i;
    logic [9:0]  req0_addr_i;
    logic [31:0] req0_wdata_i;
    logic [3:0]  req0_wmask_i;
    logic        rsp0_valid_o;
    logic [31:0] rsp0_rdata_o;
    logic        req1_valid_i, req1_ready_o, req1_we_i;
    logic [9:0]  req1_addr_i;
    logic [31:0] req1_wdata_i;
    logic [3:0]  req1_wmask_i;
    logic        rsp1_valid_o;
    logic [31:0] rsp1_rdata_o;
    logic        sram_csb0_o, sram_web0_o;
    logic [3:0]  sram_wmask0_o;
    logic [9:0]  sram_addr0_o;
    logic [31:0] sram_din0_o;
    logic [31:0] sram_dout0_i;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [0:1023];

`ifdef SRAM_PORT_ARBITER_FIXED_PRIO_EN
    logic [3:0] exp_g = 4'b0000;
`else
    logic [3:0] exp_g = 4'b1010;
`endif

    sram_port_arbiter dut (
        .clk_i         (clk),
        .rst_ni        (rst_ni),
        .req0_valid_i  (req0_valid_i),
        .req0_ready_o  (req0_ready_o),
        .req0_we_i     (req0_we_i),
        .req0_addr_i   (req0_addr_i),
        .req0_wdata_i  (req0_wdata_i),
        .req0_wmask_i  (req0_wmask_i),
        .rsp0_valid_o  (rsp0_valid_o),
        .rsp0_rdata_o  (rsp0_rdata_o),
        .req1_valid_i  (req1_valid_i),
        .req1_ready_o  (req1_ready_o),
        .req1_we_i     (req1_we_i),
        .req1_addr_i   (req1_addr_i),
        .req1_wdata_i  (req1_wdata_i),
        .req1_wmask_i  (req1_wmask_i),
        .rsp1_valid_o  (rsp1_valid_o),
        .rsp1_rdata_o  (rsp1_rdata_o),
        .sram_csb0_o   (sram_csb0_o),
        .sram_web0_o   (sram_web0_o),
        .sram_wmask0_o (sram_wmask0_o),
        .sram_addr0_o  (sram_addr0_o),
        .sram_din0_o   (sram_din0_o),
        .sram_dout0_i  (sram_dout0_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Macro model: writes on negedge, read data appears after the posedge.
    always @(negedge clk) begin
        if (!sram_csb0_o && !sram_web0_o) begin
            for (int b = 0; b < 4; b++) begin
                if (sram_wmask0_o[b]) begin
                    mem[sram_addr0_o][8*b +: 8] <= sram_din0_o[8*b +: 8];
                end
            end
        end
    end

    always @(posedge clk) begin
        if (!sram_csb0_o && sram_web0_o) begin
            sram_dout0_i <= mem[sram_addr0_o];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input bit n, input bit v, input bit we,
                           input logic [9:0] a, input logic [31:0] d,
                           input logic [3:0] m);
        if (n == 1'b0) begin
            req0_valid_i = v; req0_we_i = we; req0_addr_i = a;
            req0_wdata_i = d; req0_wmask_i = m;
        end else begin
            req1_valid_i = v; req1_we_i = we; req1_addr_i = a;
            req1_wdata_i = d; req1_wmask_i = m;
        end
    endtask

    task automatic idle_all();
        set_req(1'b0, 1'b0, 1'b0, 10'h0, 32'h0, 4'h0);
        set_req(1'b1, 1'b0, 1'b0, 10'h0, 32'h0, 4'h0);
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        idle_all();
        repeat (3) tick();
        set_req(1'b0, 1'b1, 1'b1, 10'h5, 32'h5, 4'hF);
        #1;
        checks++;
        if ({req0_ready_o, req1_ready_o, rsp0_valid_o, rsp1_valid_o,
             sram_csb0_o, sram_web0_o} !== 6'b000011) begin
            errors++;
            $display("FAIL rst_ctrl got %b exp %b",
                     {req0_ready_o, req1_ready_o, rsp0_valid_o,
                      rsp1_valid_o, sram_csb0_o, sram_web0_o}, 6'b000011);
        end
        checks++;
        if ({rsp0_rdata_o, rsp1_rdata_o} !== 64'h0) begin
            errors++;
            $display("FAIL rst_rdata got %h exp 0",
                     {rsp0_rdata_o, rsp1_rdata_o});
        end
        checks++;
        if ({sram_addr0_o, sram_din0_o, sram_wmask0_o} !== 46'h0) begin
            errors++;
            $display("FAIL rst_bus got %h exp 0",
                     {sram_addr0_o, sram_din0_o, sram_wmask0_o});
        end
        idle_all();
        tick();
        rst_ni = 1'b1;
    endtask

    task automatic test_single();
        tick();
        set_req(1'b0, 1'b1, 1'b1, 10'h10, 32'hDEADBEEF, 4'hF);
        #1;
        checks++;
        if ({req0_ready_o, req1_ready_o, sram_csb0_o, sram_web0_o}
            !== 4'b1000) begin
            errors++;
            $display("FAIL single_wr_ctl got %b exp 1000",
                     {req0_ready_o, req1_ready_o, sram_csb0_o, sram_web0_o});
        end
        checks++;
        if ({sram_addr0_o, sram_din0_o, sram_wmask0_o} !==
            {10'h10, 32'hDEADBEEF, 4'hF}) begin
            errors++;
            $display("FAIL single_wr_bus got %h exp %h",
                     {sram_addr0_o, sram_din0_o, sram_wmask0_o},
                     {10'h10, 32'hDEADBEEF, 4'hF});
        end
        tick();
        set_req(1'b0, 1'b1, 1'b0, 10'h10, 32'h0, 4'h0);
        #1;
        checks++;
        if ({req0_ready_o, sram_csb0_o, sram_web0_o} !== 3'b101) begin
            errors++;
            $display("FAIL single_rd_ctl got %b exp 101",
                     {req0_ready_o, sram_csb0_o, sram_web0_o});
        end
        tick();
        idle_all();
        #1;
        checks++;
        if ({rsp0_valid_o, rsp1_valid_o, rsp0_rdata_o} !==
            {2'b10, 32'h0}) begin
            errors++;
            $display("FAIL single_wr_ack got %h exp %h",
                     {rsp0_valid_o, rsp1_valid_o, rsp0_rdata_o},
                     {2'b10, 32'h0});
        end
        tick();
        checks++;
        if ({rsp0_valid_o, rsp1_valid_o, rsp0_rdata_o} !==
            {2'b10, 32'hDEADBEEF}) begin
            errors++;
            $display("FAIL single_rd_rsp got %h exp %h",
                     {rsp0_valid_o, rsp1_valid_o, rsp0_rdata_o},
                     {2'b10, 32'hDEADBEEF});
        end
        tick();
        checks++;
        if ({rsp0_valid_o, rsp1_valid_o} !== 2'b00) begin
            errors++;
            $display("FAIL single_rsp_drop got %b exp 00",
                     {rsp0_valid_o, rsp1_valid_o});
        end
    endtask

    task automatic test_byte_mask();
        bit          we_t [5] = '{1, 1, 0, 1, 0};
        logic [31:0] wd_t [5] = '{32'hFFFFFFFF, 32'h0, 32'h0, 32'h0, 32'h0};
        logic [3:0]  wm_t [5] = '{4'hF, 4'h5, 4'h0, 4'h0, 4'h0};
        logic [31:0] rd_t [5] = '{32'h0, 32'h0, 32'hFF00FF00,
                                  32'h0, 32'hFF00FF00};
        for (int k = 0; k < 7; k++) begin
            tick();
            if (k < 5) begin
                set_req(1'b0, 1'b1, we_t[k], 10'h20, wd_t[k], wm_t[k]);
            end else begin
                idle_all();
            end
            #1;
            if (k >= 2) begin
                checks++;
                if ({rsp0_valid_o, rsp0_rdata_o} !== {1'b1, rd_t[k-2]}) begin
                    errors++;
                    $display("FAIL mask_rsp%0d got %h exp %h", k - 2,
                             {rsp0_valid_o, rsp0_rdata_o},
                             {1'b1, rd_t[k-2]});
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        tick();
        set_req(1'b1, 1'b1, 1'b1, 10'h3F, 32'h12345678, 4'hF);
        #1;
        checks++;
        if ({req0_ready_o, req1_ready_o, sram_web0_o} !== 3'b010) begin
            errors++;
            $display("FAIL b2b_wr_ctl got %b exp 010",
                     {req0_ready_o, req1_ready_o, sram_web0_o});
        end
        tick();
        set_req(1'b1, 1'b1, 1'b0, 10'h3F, 32'h0, 4'h0);
        tick();
        idle_all();
        #1;
        checks++;
        if ({rsp0_valid_o, rsp1_valid_o, rsp1_rdata_o} !==
            {2'b01, 32'h0}) begin
            errors++;
            $display("FAIL b2b_ack got %h exp %h",
                     {rsp0_valid_o, rsp1_valid_o, rsp1_rdata_o},
                     {2'b01, 32'h0});
        end
        tick();
        checks++;
        if ({rsp0_valid_o, rsp1_valid_o, rsp1_rdata_o} !==
            {2'b01, 32'h12345678}) begin
            errors++;
            $display("FAIL b2b_rd got %h exp %h",
                     {rsp0_valid_o, rsp1_valid_o, rsp1_rdata_o},
                     {2'b01, 32'h12345678});
        end
    endtask

    task automatic test_contention();
        bit id;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (k < 4) begin
                set_req(1'b0, 1'b1, 1'b0, 10'h1, 32'h11111111, 4'h3);
                set_req(1'b1, 1'b1, 1'b0, 10'h2, 32'h22222222, 4'hC);
            end else begin
                idle_all();
            end
            #1;
            if (k < 4) begin
                checks++;
                if ({req1_ready_o, req0_ready_o} !==
                    (exp_g[k] ? 2'b10 : 2'b01)) begin
                    errors++;
                    $display("FAIL cont_grant%0d got %b exp %b", k,
                             {req1_ready_o, req0_ready_o},
                             exp_g[k] ? 2'b10 : 2'b01);
                end
                checks++;
                if (sram_addr0_o !== (exp_g[k] ? 10'h2 : 10'h1)) begin
                    errors++;
                    $display("FAIL cont_addr%0d got %h exp %h", k,
                             sram_addr0_o, exp_g[k] ? 10'h2 : 10'h1);
                end
            end
            if (k >= 2) begin
                id = exp_g[k-2];
                checks++;
                if ({rsp1_valid_o, rsp0_valid_o} !==
                    (id ? 2'b10 : 2'b01)) begin
                    errors++;
                    $display("FAIL cont_rspv%0d got %b exp %b", k - 2,
                             {rsp1_valid_o, rsp0_valid_o},
                             id ? 2'b10 : 2'b01);
                end
                checks++;
                if ((id ? rsp1_rdata_o : rsp0_rdata_o) !==
                    (id ? 32'h5A5A0002 : 32'hA5A50001)) begin
                    errors++;
                    $display("FAIL cont_rdata%0d got %h exp %h", k - 2,
                             id ? rsp1_rdata_o : rsp0_rdata_o,
                             id ? 32'h5A5A0002 : 32'hA5A50001);
                end
            end
        end
    endtask

    task automatic test_idle();
        logic [45:0] hold;
        hold = exp_g[3] ? {10'h2, 32'h22222222, 4'hC}
                        : {10'h1, 32'h11111111, 4'h3};
        idle_all();
        for (int k = 0; k < 10; k++) begin
            tick();
            checks++;
            if ({sram_csb0_o, sram_web0_o} !== 2'b11) begin
                errors++;
                $display("FAIL idle_ctl%0d got %b exp 11", k,
                         {sram_csb0_o, sram_web0_o});
            end
            checks++;
            if ({sram_addr0_o, sram_din0_o, sram_wmask0_o} !== hold) begin
                errors++;
                $display("FAIL idle_bus%0d got %h exp %h", k,
                         {sram_addr0_o, sram_din0_o, sram_wmask0_o}, hold);
            end
        end
    endtask

    task automatic test_reset_midflight();
        tick();
        set_req(1'b0, 1'b1, 1'b0, 10'h1, 32'h0, 4'h0);
        tick();
        set_req(1'b0, 1'b1, 1'b0, 10'h1, 32'h0, 4'h0);
        set_req(1'b1, 1'b1, 1'b0, 10'h2, 32'h0, 4'h0);
        #1;
        rst_ni = 1'b0;
        #1;
        checks++;
        if ({sram_csb0_o, sram_web0_o, req0_ready_o, req1_ready_o,
             rsp0_valid_o, rsp1_valid_o} !== 6'b110000) begin
            errors++;
            $display("FAIL midrst_async got %b exp 110000",
                     {sram_csb0_o, sram_web0_o, req0_ready_o, req1_ready_o,
                      rsp0_valid_o, rsp1_valid_o});
        end
        for (int k = 0; k < 2; k++) begin
            tick();
            checks++;
            if ({rsp0_valid_o, rsp1_valid_o, sram_csb0_o} !== 3'b001) begin
                errors++;
                $display("FAIL midrst_hold%0d got %b exp 001", k,
                         {rsp0_valid_o, rsp1_valid_o, sram_csb0_o});
            end
        end
        rst_ni = 1'b1;
        #1;
        checks++;
        if ({req0_ready_o, req1_ready_o} !== 2'b10) begin
            errors++;
            $display("FAIL midrst_tie got %b exp 10",
                     {req0_ready_o, req1_ready_o});
        end
        tick();
        idle_all();
        #1;
        checks++;
        if ({rsp0_valid_o, rsp1_valid_o, rsp0_rdata_o} !==
            {2'b00, 32'h0}) begin
            errors++;
            $display("FAIL midrst_norsp got %h exp %h",
                     {rsp0_valid_o, rsp1_valid_o, rsp0_rdata_o},
                     {2'b00, 32'h0});
        end
        tick();
        checks++;
        if ({rsp0_valid_o, rsp1_valid_o, rsp0_rdata_o} !==
            {2'b10, 32'hA5A50001}) begin
            errors++;
            $display("FAIL midrst_post got %h exp %h",
                     {rsp0_valid_o, rsp1_valid_o, rsp0_rdata_o},
                     {2'b10, 32'hA5A50001});
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem[i] = 32'h0;
        end
        mem[1] = 32'hA5A50001;
        mem[2] = 32'h5A5A0002;
        sram_dout0_i = 32'h0;
        test_reset();
        test_single();
        test_byte_mask();
        test_back_to_back();
        test_contention();
        test_idle();
        test_reset_midflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Shares the single read/write port (port 0) of the dual-port SRAM macro between two requesters, e.g. a TL-UL data adapter and a debug/DMA loader.
- Grants at most one access per cycle using round-robin selection.
- Drives the macro's active-low chip select, write enable and byte mask.
- Returns a registered, in-order response to the requester that issued the access.
- Port 1 (read-only) of the macro is outside this block.

Parameters:
- ADDR_WIDTH, 10, word address width; must match the macro.
- DATA_WIDTH, 32, data width; must match the macro.
- NUM_WMASKS, 4, byte-lane count (DATA_WIDTH/8).

Ports:
- clk_i  in  1  clock; the same net drives macro clk0.
- rst_ni  in  1  asynchronous active-low reset.
- reqN_valid_i  in  1  request valid, N = 0 or 1.
- reqN_ready_o  out  1  request granted this cycle.
- reqN_we_i  in  1  1 = write, 0 = read.
- reqN_addr_i  in  ADDR_WIDTH  word address.
- reqN_wdata_i  in  DATA_WIDTH  write data.
- reqN_wmask_i  in  NUM_WMASKS  byte enables.
- rspN_valid_o  out  1  response valid, one cycle.
- rspN_rdata_o  out  DATA_WIDTH  read data.
- sram_csb0_o  out  1  chip select, active low.
- sram_web0_o  out  1  write enable, active low.
- sram_wmask0_o  out  NUM_WMASKS  byte mask.
- sram_addr0_o  out  ADDR_WIDTH  address.
- sram_din0_o  out  DATA_WIDTH  write data.
- sram_dout0_i  in  DATA_WIDTH  macro read data.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous, active-low (rst_ni). The clock is clk_i.
- Reset values: reqN_ready_o 0, rspN_valid_o 0, rspN_rdata_o 0, sram_csb0_o 1, sram_web0_o 1, all other sram_* outputs 0. The round-robin pointer resets to "requester 1 last granted", so requester 0 wins the first tie.
- Handshake: valid/ready. The requester holds all fields stable while valid is high and ready is low.
  - ready is combinational from valid and the arbiter pointer. It has no dependency on responses: no backpressure, so the block accepts one access every cycle.
  - A transfer occurs when valid && ready.
- Arbitration:
  - If only one requester is valid, it is granted.
  - If both are valid, the requester not granted last is granted.
  - The pointer updates only on a grant.
- Issue cycle T (the transfer cycle):
  - sram_* outputs are driven combinationally from the granted request: csb0 = 0, web0 = !we.
  - With no grant, csb0 = 1 and web0 = 1; addr, din and wmask hold their last value, so the bus does not toggle when idle.
  - The macro samples on the posedge ending T. Read data is valid on sram_dout0_i before the posedge ending T+1.
- Response pipeline: a 2-entry shift register of {valid, id, we}.
  - At the posedge ending T+1, the block registers sram_dout0_i into rspN_rdata_o for the issuing id.
  - rspN_valid_o is high in cycle T+2, for one cycle.
  - Fixed latency: 2 cycles from grant to response, for both reads and writes.
  - A write response carries rdata = 0. It serves as a completion acknowledgement only.
  - rsp(1-N)_rdata_o holds its previous value when the response is not for it.
- Back-to-back: grants in consecutive cycles produce responses in consecutive cycles, in grant order.
- wmask = 0 on a write: the access is still issued, no byte changes, and a write ack is returned.
- Write then read to the same address in consecutive cycles: the read returns the new data. The macro writes on the negedge of the write's issue cycle, before the read is sampled.
- Reset asserted mid-operation: the pipeline is cleared immediately. In-flight accesses produce no response. csb0 goes to 1 asynchronously.
- No state machine beyond the pointer and the pipeline. A grant is never withheld when some request is valid.

Optional Feature:
- Macro: SRAM_PORT_ARBITER_FIXED_PRIO_EN.
- Defined: requester 0 always wins ties. The pointer register is removed, so requester 1 can starve.
- Undefined (default): round-robin as above.

Decomposition:
- Package sram_arb_pkg holds:
  - the requester id typedef (1 bit);
  - the pipeline entry struct {valid, id, we};
  - the constant RSP_LATENCY = 2;
  - the reset-pointer constant.
- One sub-module, sram_arb_rr: a 2-way round-robin picker with an ifdef for fixed priority. It takes valid[1:0] and advance, and outputs a one-hot grant[1:0].

Test Plan:
- Single requester: req0 writes 0xDEADBEEF, mask 4'hF, to addr 0x10. Then req0 reads 0x10. Expect rsp0_valid at T+2 for each, and read rdata = 0xDEADBEEF.
- Byte mask: write 0xFFFFFFFF to 0x20. Then write 0x00000000 with mask 4'b0101. Read 0x20; expect 0xFF00FF00.
- Contention: both requesters valid for 4 cycles, reading 0x1/0x2. Expect grants 0,1,0,1 and responses alternating rsp0/rsp1 at T+2 with the correct data. With FIXED_PRIO_EN defined, expect grants 0,0,0,0 and req1 ready low throughout.
- Back-to-back dependency: req1 writes 0x12345678 to 0x3F at cycle T, then reads 0x3F at T+1. Expect rsp1 ack at T+2 and rdata 0x12345678 at T+3.
- Idle: no valid for 10 cycles. Expect csb0 = 1, web0 = 1, and no change on addr0/din0.
- Reset mid-flight: issue a read, then assert rst_ni low in cycle T+1. Expect no rsp_valid, csb0 = 1 immediately, and after release a tie grants req0 first.
